// File: rtl/neopixel_frame_source.sv
// Double-buffered NeoPixel frame store: host fills the back bank, a commit swaps banks at the
// next frame boundary, and the front bank is streamed as brightness-scaled GRB bytes.
module neopixel_frame_source #(
  parameter int NUM_PIXELS = 16,
  parameter int IDX_W      = 4
) (
  input  logic             clk_20M,
  input  logic             nrst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [7:0]       wr_red,
  input  logic [7:0]       wr_green,
  input  logic [7:0]       wr_blue,
  input  logic             commit,
  output logic             commit_pending,
  input  logic [7:0]       brightness,
  input  logic             frame_req,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic [7:0]       byte_data,
  output logic             byte_last,
  output logic             overrun
);

  localparam int PIX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam logic [IDX_W:0] NPIX     = (IDX_W+1)'(NUM_PIXELS);
  localparam logic [PIX_W-1:0] PIX_MAX = PIX_W'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM} state_t;

  state_t state_q, state_d;

  // Pixels stored as {R, G, B}; bank_sel_q names the front bank.
  logic [1:0][NUM_PIXELS-1:0][23:0] bank_q;
  logic             bank_sel_q, bank_sel_d;
  logic [7:0]       bright_q, bright_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [1:0]       col_q, col_d;
  logic             valid_q, valid_d;
  logic [7:0]       data_q, data_d;
  logic             last_q, last_d;
  logic             pend_q, pend_d;
  logic             ovr_q, ovr_d;

  logic        start;
  logic        wr_ok;
  logic        xfer;
  logic [23:0] px;
  logic [7:0]  chan;
  logic [15:0] prod;

  assign start = (state_q == S_IDLE) && frame_req;
  assign wr_ok = wr_en && ({1'b0, wr_idx} < NPIX);
  assign xfer  = valid_q && byte_ready;

  assign px = bank_q[bank_sel_q][pix_q];

  always_comb begin
    chan = px[7:0];
    case (col_q)
      2'd0:    chan = px[15:8];
      2'd1:    chan = px[23:16];
      default: chan = px[7:0];
    endcase
  end

  // (brightness+1) scaling makes 255 an exact pass-through and 0 a full blank.
  assign prod = {8'd0, chan} * ({8'd0, bright_q} + 16'd1);

  always_ff @(posedge clk_20M) begin
    if (!nrst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (frame_req) state_d = S_LOAD;
      S_LOAD:   state_d = S_STREAM;
      S_STREAM: if (xfer) state_d = last_q ? S_IDLE : S_LOAD;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bank_sel_d = bank_sel_q;
    bright_d   = bright_q;
    pix_d      = pix_q;
    col_d      = col_q;
    valid_d    = valid_q;
    data_d     = data_q;
    last_d     = last_q;
    pend_d     = pend_q | commit;
    ovr_d      = frame_req && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (pend_q || commit) bank_sel_d = ~bank_sel_q;
          pend_d   = 1'b0;
          bright_d = brightness;
          pix_d    = '0;
          col_d    = 2'd0;
        end
      end
      S_LOAD: begin
        data_d  = prod[15:8];
        valid_d = 1'b1;
        last_d  = (pix_q == PIX_MAX) && (col_q == 2'd2);
      end
      S_STREAM: begin
        if (xfer) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (!last_q) begin
            if (col_q == 2'd2) begin
              col_d = 2'd0;
              pix_d = pix_q + 1'b1;
            end else begin
              col_d = col_q + 2'd1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_20M) begin
    if (!nrst) begin
      bank_sel_q <= 1'b0;
      bright_q   <= 8'd0;
      pix_q      <= '0;
      col_q      <= 2'd0;
      valid_q    <= 1'b0;
      data_q     <= 8'd0;
      last_q     <= 1'b0;
      pend_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      bank_sel_q <= bank_sel_d;
      bright_q   <= bright_d;
      pix_q      <= pix_d;
      col_q      <= col_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      last_q     <= last_d;
      pend_q     <= pend_d;
      ovr_q      <= ovr_d;
    end
  end

  // Writes target the pre-swap back bank, so a write in the swap cycle joins the new frame.
  always_ff @(posedge clk_20M) begin
    if (!nrst) begin
      bank_q <= '0;
    end else if (wr_ok) begin
      bank_q[~bank_sel_q][wr_idx[PIX_W-1:0]] <= {wr_red, wr_green, wr_blue};
    end
  end

  assign commit_pending = pend_q;
  assign byte_valid     = valid_q;
  assign byte_data      = data_q;
  assign byte_last      = last_q;
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_neopixel_frame_source.sv
// Scoreboard bench for neopixel_frame_source: frame requests push expected GRB bytes,
// a negedge monitor pops and compares every accepted byte.
`timescale 1ns/1ps
module tb_neopixel_frame_source;

  localparam int NP = 16;
  localparam int IW = 5;

  logic          clk_20M = 1'b0;
  logic          nrst;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [7:0]    wr_red, wr_green, wr_blue;
  logic          commit, commit_pending;
  logic [7:0]    brightness;
  logic          frame_req;
  logic          byte_valid, byte_ready, byte_last, overrun;
  logic [7:0]    byte_data;

  always #25 clk_20M = ~clk_20M;

  neopixel_frame_source #(.NUM_PIXELS(NP), .IDX_W(IW)) dut (
    .clk_20M(clk_20M), .nrst(nrst),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_red(wr_red), .wr_green(wr_green), .wr_blue(wr_blue),
    .commit(commit), .commit_pending(commit_pending), .brightness(brightness),
    .frame_req(frame_req), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .byte_data(byte_data), .byte_last(byte_last), .overrun(overrun)
  );

  typedef struct { logic [7:0] d; logic l; } exp_t;
  exp_t sbq[$];

  int vectors = 0;
  int errors  = 0;
  int acc_cnt = 0;
  int frames_done = 0;
  int fidx = 0;
  logic [7:0] cap [3*NP];

  logic [23:0] mbank [2][NP];
  int msel = 0;
  bit mpend = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: a byte is transferred at the posedge following a negedge with valid && ready.
  always @(negedge clk_20M) begin
    exp_t e;
    if (!nrst) fidx = 0;
    else if (byte_valid && byte_ready) begin
      acc_cnt++;
      if (sbq.size() == 0) begin
        vectors++; errors++;
        $display("FAIL unexpected_byte: got 0x%0h with no expected byte queued", byte_data);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("byte_data[%0d]", fidx), byte_data, e.d);
        chk($sformatf("byte_last[%0d]", fidx), byte_last, e.l);
      end
      if (fidx < 3*NP) cap[fidx] = byte_data;
      fidx++;
      if (byte_last) begin
        chk("frame_len", fidx, 3*NP);
        fidx = 0;
        frames_done++;
      end
    end
  end

  function automatic logic [7:0] scale(input int c, input int b);
    return 8'((c * (b + 1)) / 256);
  endfunction

  task automatic push_frame();
    exp_t e;
    logic [23:0] p;
    for (int i = 0; i < NP; i++) begin
      p = mbank[msel][i];
      for (int c = 0; c < 3; c++) begin
        e.d = scale((c == 0) ? int'(p[15:8]) : (c == 1) ? int'(p[23:16]) : int'(p[7:0]),
                    int'(brightness));
        e.l = (i == NP-1) && (c == 2);
        sbq.push_back(e);
      end
    end
  endtask

  task automatic wr_px(input int idx, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    wr_en = 1; wr_idx = idx[IW-1:0]; wr_red = r; wr_green = g; wr_blue = b;
    if (idx < NP) mbank[msel ^ 1][idx] = {r, g, b};
    @(posedge clk_20M); #1 wr_en = 0;
  endtask

  task automatic do_commit();
    commit = 1; mpend = 1;
    @(posedge clk_20M); #1 commit = 0;
  endtask

  // Frame request from IDLE, optionally with a same-cycle commit and write.
  task automatic req(input bit wc = 0, input bit we = 0, input int wi = 0,
                     input logic [7:0] r = 0, input logic [7:0] g = 0, input logic [7:0] b = 0);
    frame_req = 1; commit = wc; wr_en = we;
    wr_idx = wi[IW-1:0]; wr_red = r; wr_green = g; wr_blue = b;
    if (we && wi < NP) mbank[msel ^ 1][wi] = {r, g, b};
    if (wc) mpend = 1;
    if (mpend) begin msel = msel ^ 1; mpend = 0; end
    push_frame();
    @(posedge clk_20M); #1 frame_req = 0; commit = 0; wr_en = 0;
  endtask

  task automatic wait_frames(input int n);
    int t = 0;
    while (frames_done < n && t < 2000) begin @(posedge clk_20M); t++; end
    #1;
    chk($sformatf("frame_%0d_done", n), frames_done >= n, 1);
  endtask

  task automatic wait_valid();
    int t = 0;
    do begin @(posedge clk_20M); #1; t++; end while (!byte_valid && t < 20);
    chk("valid_timeout", byte_valid, 1);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    int base;
    nrst = 0; wr_en = 0; wr_idx = 0; wr_red = 0; wr_green = 0; wr_blue = 0;
    commit = 0; brightness = 8'd255; frame_req = 0; byte_ready = 1;
    for (int b = 0; b < 2; b++) for (int i = 0; i < NP; i++) mbank[b][i] = '0;
    repeat (3) @(posedge clk_20M); #1;
    chk("rst_valid", byte_valid, 0);
    chk("rst_data", byte_data, 0);
    chk("rst_last", byte_last, 0);
    chk("rst_pending", commit_pending, 0);
    chk("rst_overrun", overrun, 0);
    nrst = 1;
    @(posedge clk_20M); #1;

    // empty frame after reset
    req();
    wait_frames(1);
    chk("idle_valid", byte_valid, 0);

    // commit and first real frame
    wr_px(0, 8'h12, 8'h34, 8'h56);
    wr_px(15, 8'hFF, 8'h00, 8'h80);
    do_commit();
    chk("pending_set", commit_pending, 1);
    req();
    chk("pending_clr", commit_pending, 0);
    wait_frames(2);
    chk("f2_b0", cap[0], 8'h34); chk("f2_b1", cap[1], 8'h12); chk("f2_b2", cap[2], 8'h56);
    chk("f2_b45", cap[45], 8'h00); chk("f2_b46", cap[46], 8'hFF); chk("f2_b47", cap[47], 8'h80);

    // brightness 127, changed to 0 mid-frame
    brightness = 8'd127;
    req();
    repeat (10) @(posedge clk_20M); #1 brightness = 8'd0;
    wait_frames(3);
    chk("f3_b0", cap[0], 8'h1A); chk("f3_b1", cap[1], 8'h09); chk("f3_b2", cap[2], 8'h2B);
    chk("f3_b46", cap[46], 8'h7F); chk("f3_b47", cap[47], 8'h40);
    req();
    wait_frames(4);
    chk("f4_b0", cap[0], 8'h00);

    // backpressure on byte 3
    brightness = 8'd255;
    byte_ready = 0;
    req();
    for (int k = 0; k < 3; k++) begin
      wait_valid();
      if (k == 2) begin
        ok = 1;
        repeat (50) begin
          @(posedge clk_20M); #1;
          if (!(byte_valid && byte_data == 8'h56 && !byte_last)) ok = 0;
        end
        chk("stall_stable", ok, 1);
      end
      byte_ready = 1;
      @(posedge clk_20M); #1 byte_ready = 0;
      chk($sformatf("handshake_%0d", k), byte_valid, 0);
    end
    byte_ready = 1;
    wait_frames(5);

    // overrun during streaming, commit pending across it
    req();
    repeat (4) @(posedge clk_20M); #1;
    do_commit();
    frame_req = 1;
    @(posedge clk_20M); #1 frame_req = 0;
    chk("overrun_hi", overrun, 1);
    @(posedge clk_20M); #1;
    chk("overrun_lo", overrun, 0);
    chk("pending_kept", commit_pending, 1);
    wait_frames(6);
    wr_px(20, 8'h11, 8'h22, 8'h33);
    req();
    wait_frames(7);

    // write without commit, then commit with frame_req plus a swap-cycle write
    wr_px(0, 8'hAA, 8'hBB, 8'hCC);
    req();
    wait_frames(8);
    chk("nocommit_b0", cap[0], 8'h00);
    req(1, 1, 1, 8'h01, 8'h02, 8'h03);
    wait_frames(9);
    chk("swap_b0", cap[0], 8'hBB); chk("swap_b1", cap[1], 8'hAA);
    chk("swapwr_b3", cap[3], 8'h02); chk("swapwr_b4", cap[4], 8'h01);
    chk("swapwr_b5", cap[5], 8'h03);

    // reset mid-stream
    base = acc_cnt;
    req();
    begin
      int t = 0;
      while (acc_cnt < base + 10 && t < 500) begin @(posedge clk_20M); t++; end
    end
    #1 byte_ready = 0;
    @(posedge clk_20M); #1;
    chk("pre_rst_valid", byte_valid, 1);
    nrst = 0;
    @(posedge clk_20M); #1;
    chk("midrst_valid", byte_valid, 0);
    chk("midrst_data", byte_data, 0);
    chk("midrst_last", byte_last, 0);
    sbq.delete();
    for (int b = 0; b < 2; b++) for (int i = 0; i < NP; i++) mbank[b][i] = '0;
    msel = 0; mpend = 0;
    nrst = 1; byte_ready = 1;
    @(posedge clk_20M); #1;
    req();
    wait_frames(10);
    chk("sb_empty", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
